// File: rtl/struct_arb_pkg.sv
// Shared definitions for the struct field arbiter: struct layout, field and FSM
// enums, and helpers that read/write one field of the 41-bit struct.
package struct_arb_pkg;

    localparam int STRUCT_W = 41;
    localparam int FLAG_BIT = 40;
    localparam int VALUE_HI = 39;
    localparam int VALUE_LO = 8;
    localparam int TAG_HI   = 7;
    localparam int TAG_LO   = 0;

    typedef enum logic [1:0] {
        FIELD_FLAG  = 2'd0,
        FIELD_VALUE = 2'd1,
        FIELD_TAG   = 2'd2,
        FIELD_WHOLE = 2'd3
    } field_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // Selected field, zero-extended and right-justified.
    function automatic logic [STRUCT_W-1:0] field_read(input logic [STRUCT_W-1:0] s,
                                                       input field_e f);
        logic [STRUCT_W-1:0] r;
        r = '0;
        case (f)
            FIELD_FLAG:  r[0] = s[FLAG_BIT];
            FIELD_VALUE: r[VALUE_HI-VALUE_LO:0] = s[VALUE_HI:VALUE_LO];
            FIELD_TAG:   r[TAG_HI-TAG_LO:0] = s[TAG_HI:TAG_LO];
            default:     r = s;
        endcase
        return r;
    endfunction

    function automatic logic [STRUCT_W-1:0] field_write(input logic [STRUCT_W-1:0] s,
                                                        input field_e f,
                                                        input logic [STRUCT_W-1:0] w);
        logic [STRUCT_W-1:0] r;
        r = s;
        case (f)
            FIELD_FLAG:  r[FLAG_BIT] = w[0];
            FIELD_VALUE: r[VALUE_HI:VALUE_LO] = w[VALUE_HI-VALUE_LO:0];
            FIELD_TAG:   r[TAG_HI:TAG_LO] = w[TAG_HI-TAG_LO:0];
            default:     r = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational one-hot winner select. Round-robin from a pointer when
// STRUCT_ARB_RR_EN is defined, otherwise a lowest-index priority encoder.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDXW = 2
) (
    input  logic [NREQ-1:0] req,
`ifdef STRUCT_ARB_RR_EN
    input  logic [IDXW-1:0] ptr,
    output logic [IDXW-1:0] ptr_next,
`endif
    output logic [NREQ-1:0] grant,
    output logic [IDXW-1:0] grant_idx
);

`ifdef STRUCT_ARB_RR_EN
    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int off = 0; off < NREQ; off++) begin
            if (!found && req[(int'(ptr) + off) % NREQ]) begin
                found = 1'b1;
                grant[(int'(ptr) + off) % NREQ] = 1'b1;
                grant_idx = IDXW'((int'(ptr) + off) % NREQ);
            end
        end
        ptr_next = (grant_idx == IDXW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end
`else
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_prio
            if (gi == 0) begin : g_first
                assign grant[gi] = req[gi];
            end else begin : g_rest
                assign grant[gi] = req[gi] & ~(|req[gi-1:0]);
            end
        end
    endgenerate

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) grant_idx = IDXW'(i);
        end
    end
`endif

endmodule

// File: rtl/struct_field_arbiter.sv
// Arbitrates field/whole-struct reads and writes of a shared 41-bit struct
// among NREQ requesters. Define STRUCT_ARB_RR_EN for round-robin arbitration.
module struct_field_arbiter
    import struct_arb_pkg::*;
#(
    parameter int                  NREQ      = 4,
    parameter logic [STRUCT_W-1:0] RESET_VAL = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          req_we,
    input  logic [2*NREQ-1:0]        req_field,
    input  logic [STRUCT_W*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]          gnt,
    output logic                     done,
    output logic [STRUCT_W-1:0]      rdata,
    output logic                     busy,
    output logic [STRUCT_W-1:0]      struct_q
);

    localparam int IDXW = $clog2(NREQ);

    state_e              state_reg, state_next;
    logic [NREQ-1:0]     gnt_reg;
    logic                done_reg;
    logic [STRUCT_W-1:0] rdata_reg;
    logic [STRUCT_W-1:0] struct_reg, struct_next;
    logic                we_reg;
    field_e              field_reg;
    logic [STRUCT_W-1:0] wdata_reg;

    field_e              field_arr [NREQ];
    logic [STRUCT_W-1:0] wdata_arr [NREQ];
    logic [NREQ-1:0]     win_onehot;
    logic [IDXW-1:0]     win_idx;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign field_arr[gi] = field_e'(req_field[2*gi +: 2]);
            assign wdata_arr[gi] = req_wdata[STRUCT_W*gi +: STRUCT_W];
        end
    endgenerate

`ifdef STRUCT_ARB_RR_EN
    logic [IDXW-1:0] ptr_reg, ptr_next;

    rr_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) u_arb (
        .req       (req),
        .ptr       (ptr_reg),
        .ptr_next  (ptr_next),
        .grant     (win_onehot),
        .grant_idx (win_idx)
    );

    // Pointer only moves when a grant is actually issued.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_reg <= '0;
        end else if (state_reg == ST_IDLE && |req) begin
            ptr_reg <= ptr_next;
        end
    end
`else
    rr_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) u_arb (
        .req       (req),
        .grant     (win_onehot),
        .grant_idx (win_idx)
    );
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (|req) state_next = ST_ACCESS;
            ST_ACCESS: state_next = ST_DONE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // A write's read-back is taken from the updated struct so rdata always
    // reflects the field's new value.
    assign struct_next = we_reg ? field_write(struct_reg, field_reg, wdata_reg) : struct_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt_reg    <= '0;
            done_reg   <= 1'b0;
            rdata_reg  <= '0;
            struct_reg <= RESET_VAL;
            we_reg     <= 1'b0;
            field_reg  <= FIELD_FLAG;
            wdata_reg  <= '0;
        end else begin
            done_reg <= (state_reg == ST_ACCESS);
            case (state_reg)
                ST_IDLE: begin
                    if (|req) begin
                        gnt_reg   <= win_onehot;
                        we_reg    <= req_we[win_idx];
                        field_reg <= field_arr[win_idx];
                        wdata_reg <= wdata_arr[win_idx];
                    end
                end
                ST_ACCESS: begin
                    gnt_reg    <= '0;
                    struct_reg <= struct_next;
                    rdata_reg  <= field_read(struct_next, field_reg);
                end
                default: gnt_reg <= '0;
            endcase
        end
    end

    assign gnt      = gnt_reg;
    assign done     = done_reg;
    assign rdata    = rdata_reg;
    assign busy     = (state_reg != ST_IDLE);
    assign struct_q = struct_reg;

endmodule

// File: tb/tb_struct_field_arbiter.sv
// Scoreboard bench for struct_field_arbiter: driver predicts each transaction
// from a field-level model; a monitor checks every done pulse against the queue.
module tb_struct_field_arbiter;
    import struct_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int W    = STRUCT_W;
    localparam logic [W-1:0] RST_VAL = 41'h0DEADBEEF5A;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ-1:0]   req_we = '0;
    logic [2*NREQ-1:0] req_field = '0;
    logic [W*NREQ-1:0] req_wdata = '0;
    logic [NREQ-1:0]   gnt;
    logic              done;
    logic [W-1:0]      rdata;
    logic              busy;
    logic [W-1:0]      struct_q;

    struct_field_arbiter #(.NREQ(NREQ), .RESET_VAL(RST_VAL)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_we    (req_we),
        .req_field (req_field),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .done      (done),
        .rdata     (rdata),
        .busy      (busy),
        .struct_q  (struct_q)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int txn_no = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [NREQ-1:0] gnt;
        logic [W-1:0]    rdata;
        logic [W-1:0]    sq;
        int              cyc;
    } exp_t;
    exp_t sb_q[$];

    // Reference model: struct kept as its three named fields.
    logic        m_flag;
    logic [31:0] m_value;
    logic [7:0]  m_tag;
    int          m_ptr;

    int          s_fld [NREQ];
    logic [W-1:0] s_wd [NREQ];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        {m_flag, m_value, m_tag} = RST_VAL;
        m_ptr = 0;
    endtask

    function automatic int pick(input logic [NREQ-1:0] r);
`ifdef STRUCT_ARB_RR_EN
        for (int off = 0; off < NREQ; off++)
            if (r[(m_ptr + off) % NREQ]) return (m_ptr + off) % NREQ;
`else
        for (int i = 0; i < NREQ; i++)
            if (r[i]) return i;
`endif
        return -1;
    endfunction

    task automatic model_apply(input bit we, input int f, input logic [W-1:0] d,
                               output logic [W-1:0] rd);
        if (we) begin
            case (f)
                0: m_flag  = d[0];
                1: m_value = d[31:0];
                2: m_tag   = d[7:0];
                default: {m_flag, m_value, m_tag} = d;
            endcase
        end
        case (f)
            0: rd = {40'd0, m_flag};
            1: rd = {9'd0, m_value};
            2: rd = {33'd0, m_tag};
            default: rd = {m_flag, m_value, m_tag};
        endcase
    endtask

    task automatic randomize_stim();
        logic [63:0] tmp;
        for (int i = 0; i < NREQ; i++) begin
            s_fld[i] = $urandom_range(0, 3);
            tmp = {$urandom, $urandom};
            s_wd[i] = tmp[W-1:0];
        end
    endtask

    task automatic apply_inputs(input logic [NREQ-1:0] r, input logic [NREQ-1:0] w);
        logic [31:0] f;
        req = r;
        req_we = w;
        for (int i = 0; i < NREQ; i++) begin
            f = s_fld[i];
            req_field[2*i +: 2] = f[1:0];
            req_wdata[W*i +: W] = s_wd[i];
        end
    endtask

    // Called at a negedge with the DUT idle. mode: 0 hold inputs, 1 drop req
    // in ACCESS, 2 random traffic during ACCESS and DONE. Returns at the
    // negedge where the DUT is idle again.
    task automatic issue(input logic [NREQ-1:0] r, input logic [NREQ-1:0] w, input int mode);
        int win;
        exp_t e;
        logic [W-1:0] rd;
        apply_inputs(r, w);
        win = pick(r);
        model_apply(w[win], s_fld[win], s_wd[win], rd);
        e.gnt   = NREQ'(1) << win;
        e.rdata = rd;
        e.sq    = {m_flag, m_value, m_tag};
        e.cyc   = cyc + 2;
        sb_q.push_back(e);
`ifdef STRUCT_ARB_RR_EN
        m_ptr = (win + 1) % NREQ;
`endif
        @(posedge clk); @(negedge clk);
        if (mode == 1) apply_inputs('0, '0);
        else if (mode == 2) begin randomize_stim(); apply_inputs(NREQ'($urandom), NREQ'($urandom)); end
        @(posedge clk); @(negedge clk);
        if (mode == 2) begin randomize_stim(); apply_inputs(NREQ'($urandom), NREQ'($urandom)); end
        @(posedge clk); @(negedge clk);
    endtask

    logic [NREQ-1:0] last_gnt = '0;
    always @(negedge clk) begin
        if (done) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", {63'd0, done}, 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                txn_no++;
                chk("gnt_prev_cycle", {60'd0, last_gnt}, {60'd0, e.gnt});
                chk("gnt_low_in_done", {60'd0, gnt}, 64'd0);
                chk("rdata", {23'd0, rdata}, {23'd0, e.rdata});
                chk("struct_q", {23'd0, struct_q}, {23'd0, e.sq});
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
                chk("busy_in_done", {63'd0, busy}, 64'd1);
                $display("txn %0d: gnt=%b rdata=%h struct_q=%h", txn_no, last_gnt, rdata, struct_q);
            end
        end
        last_gnt <= gnt;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NREQ-1:0] r;
        model_reset();
        randomize_stim();
        repeat (3) @(negedge clk);
        chk("rst_struct_q", {23'd0, struct_q}, {23'd0, RST_VAL});
        chk("rst_gnt", {60'd0, gnt}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_rdata", {23'd0, rdata}, 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // All requesters held high: round-robin rotates, fixed stays on 0.
        randomize_stim();
        for (int i = 0; i < 5; i++) issue(4'b1111, 4'b0000, 0);

        // Write value 100 from requester 1.
        s_fld[1] = 1; s_wd[1] = 41'd100;
        issue(4'b0010, 4'b0010, 0);

        // Write tag 10, read it back from requester 3, then read flag.
        s_fld[0] = 2; s_wd[0] = 41'd10;
        issue(4'b0001, 4'b0001, 0);
        s_fld[3] = 2;
        issue(4'b1000, 4'b0000, 0);
        s_fld[3] = 0;
        issue(4'b1000, 4'b0000, 0);

        // Whole-struct write where the requester drops req during ACCESS.
        randomize_stim();
        s_fld[2] = 3;
        issue(4'b0100, 4'b0100, 1);

        // Reset during ACCESS of a whole-struct write.
        randomize_stim();
        s_fld[1] = 3;
        apply_inputs(4'b0010, 4'b0010);
        @(posedge clk); @(negedge clk);
        chk("mid_gnt_before_reset", {60'd0, gnt}, 64'b0010);
        reset = 1'b0;
        apply_inputs('0, '0);
        #1;
        chk("mid_rst_struct_q", {23'd0, struct_q}, {23'd0, RST_VAL});
        chk("mid_rst_gnt", {60'd0, gnt}, 64'd0);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_rdata", {23'd0, rdata}, 64'd0);
        repeat (2) @(negedge clk);
        chk("mid_rst_no_done", {63'd0, done}, 64'd0);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        chk("post_rst_struct_q", {23'd0, struct_q}, {23'd0, RST_VAL});

        // Randomized traffic with occasional idle cycles.
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                apply_inputs('0, '0);
                @(posedge clk); @(negedge clk);
                chk("idle_gnt", {60'd0, gnt}, 64'd0);
                chk("idle_busy", {63'd0, busy}, 64'd0);
            end
            randomize_stim();
            r = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            issue(r, NREQ'($urandom), $urandom_range(0, 2));
        end

        apply_inputs('0, '0);
        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
